// File: rtl/ecc_pkg.sv
// Shared Hamming(21,16) constants and syndrome classification, used by the encode and decode stages.
package ecc_pkg;

  localparam int unsigned EccDataWidth = 16;
  localparam int unsigned EccEncWidth  = 21;
  localparam int unsigned EccSynWidth  = 5;
  localparam int unsigned EccLastPos   = 21;
  localparam int unsigned EccNumParity = 5;
  localparam int unsigned EccParityPos [EccNumParity] = '{1, 2, 4, 8, 16};

  typedef enum logic [1:0] {
    SynClean,
    SynCorrected,
    SynUncorrectable
  } syn_class_e;

  // Positions are 1-based codeword positions.
  function automatic logic is_parity_pos(input int unsigned pos);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < EccNumParity; i++) begin
      if (EccParityPos[i] == pos) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/hamming_correct.sv
// Combinational Hamming(21,16) syndrome generation and single-bit correction/data extraction.
// The syndrome half and the correction half take separate codewords so they can straddle a register.
module hamming_correct
  import ecc_pkg::*;
(
  input  logic [EccEncWidth-1:0]  enc,
  output logic [EccSynWidth-1:0]  syn,
  input  logic [EccEncWidth-1:0]  cw,
  input  logic [EccSynWidth-1:0]  cw_syn,
  output logic [EccDataWidth-1:0] data,
  output syn_class_e              cls
);

  localparam logic [EccSynWidth-1:0] LastPosSyn = EccSynWidth'(EccLastPos);
  localparam logic [EccSynWidth-1:0] SynOne     = EccSynWidth'(1);

  logic [EccEncWidth-1:0]          fixed;
  logic [$clog2(EccDataWidth)-1:0] dj;

  // Each set codeword bit toggles the syndrome by its own position number.
  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < EccEncWidth; i++) begin
      syn = syn ^ ({EccSynWidth{enc[EccSynWidth'(i)]}} & EccSynWidth'(i + 1));
    end
  end

  always_comb begin
    fixed = cw;
    cls   = SynClean;
    if (cw_syn != '0) begin
      if (cw_syn <= LastPosSyn) begin
        fixed[cw_syn - SynOne] = ~cw[cw_syn - SynOne];
        cls = SynCorrected;
      end else begin
        cls = SynUncorrectable;
      end
    end
  end

  always_comb begin
    data = '0;
    dj   = '0;
    for (int unsigned i = 0; i < EccEncWidth; i++) begin
      if (!is_parity_pos(i + 1)) begin
        data[dj] = fixed[EccSynWidth'(i)];
        dj++;
      end
    end
  end

endmodule

// File: rtl/hamming_decode.sv
// Two-stage pipelined Hamming(21,16) decoder with valid/ready handshake on both sides.
// Define HAMMING_DECODE_ERR_CNT_EN to build the saturating corrected/uncorrectable counters.
module hamming_decode
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EccDataWidth,
  parameter int unsigned ENC_WIDTH  = EccEncWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ENC_WIDTH-1:0]  enc_data,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  err_corrected,
  output logic                  err_uncorrectable,
  input  logic                  clr_counts,
  output logic [15:0]           corr_count,
  output logic [15:0]           uncorr_count
);

  logic [EccSynWidth-1:0] syn_in, syn_q;
  logic [ENC_WIDTH-1:0]   cw_q;
  logic [DATA_WIDTH-1:0]  fix_data, data_q;
  syn_class_e             fix_cls;
  logic                   v1_q, v2_q, corr_q, uncorr_q;
  logic                   ld1, ld2;

  hamming_correct u_correct (
    .enc    (enc_data),
    .syn    (syn_in),
    .cw     (cw_q),
    .cw_syn (syn_q),
    .data   (fix_data),
    .cls    (fix_cls)
  );

  always_comb begin
    ld2 = !v2_q || ready_in;
    ld1 = !v1_q || ld2;
  end

  // Gated by rst so the upstream sees no acceptance while reset is held.
  assign ready_out = !rst && ld1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      cw_q  <= '0;
      syn_q <= '0;
    end else if (ld1) begin
      v1_q <= valid_in;
      if (valid_in) begin
        cw_q  <= enc_data;
        syn_q <= syn_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q     <= 1'b0;
      data_q   <= '0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
    end else if (ld2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data_q   <= fix_data;
        corr_q   <= (fix_cls == SynCorrected);
        uncorr_q <= (fix_cls == SynUncorrectable);
      end
    end
  end

  assign valid_out         = v2_q;
  assign data_out          = data_q;
  assign err_corrected     = corr_q;
  assign err_uncorrectable = uncorr_q;

`ifdef HAMMING_DECODE_ERR_CNT_EN
  logic [15:0] corr_cnt_q, uncorr_cnt_q;
  logic        out_xfer;

  assign out_xfer = v2_q && ready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (clr_counts) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (out_xfer && corr_q && (corr_cnt_q != 16'hFFFF)) begin
        corr_cnt_q <= corr_cnt_q + 16'd1;
      end
      if (out_xfer && uncorr_q && (uncorr_cnt_q != 16'hFFFF)) begin
        uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
      end
    end
  end

  assign corr_count   = corr_cnt_q;
  assign uncorr_count = uncorr_cnt_q;
`else
  logic unused_clr_counts;

  assign unused_clr_counts = clr_counts;
  assign corr_count        = '0;
  assign uncorr_count      = '0;
`endif

endmodule

// File: doc/hamming_decode.md
HAMMING_DECODE -- requirements
Module: hamming_decode

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, decoded payload width; only 16 is supported.
REQ-002 SHALL have parameter ENC_WIDTH, default 21, codeword width; only 21 is supported.
REQ-003 SHALL have port clk, input, 1, single clock; all flops update on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port enc_data, input, ENC_WIDTH, codeword from the encode stage.
REQ-006 SHALL have port valid_in, input, 1, enc_data is valid.
REQ-007 SHALL have port ready_out, output, 1, block accepts enc_data this cycle.
REQ-008 SHALL have port data_out, output, DATA_WIDTH, corrected payload.
REQ-009 SHALL have port valid_out, output, 1, data_out and its flags are valid.
REQ-010 SHALL have port ready_in, input, 1, downstream accepts data_out.
REQ-011 SHALL have port err_corrected, output, 1, single-bit error corrected, aligned with data_out.
REQ-012 SHALL have port err_uncorrectable, output, 1, uncorrectable syndrome, aligned with data_out.
REQ-013 SHALL have port clr_counts, input, 1, synchronous clear of the error counters.
REQ-014 SHALL have port corr_count, output, 16, saturating count of corrected words.
REQ-015 SHALL have port uncorr_count, output, 16, saturating count of uncorrectable words.

Function
REQ-016 SHALL map codeword position p (1..21) to enc_data[p-1]; parity bits sit at p = 1, 2, 4, 8, 16; data bits d0..d15 sit at the remaining positions in ascending order.
REQ-017 SHALL compute a 5-bit syndrome; syndrome bit k is the XOR of all enc_data bits whose position has bit k set.
REQ-018 SHALL interpret the syndrome as follows:
- syndrome 0: clean, no flags.
- syndrome 1..21: flip the bit at that position, assert err_corrected; this includes parity positions, where the data is unchanged but the flag is still set.
- syndrome 22..31: data extracted uncorrected, assert err_uncorrectable.
REQ-019 SHALL be a 2-stage pipeline. Stage 1 registers the codeword and syndrome; stage 2 registers the corrected data and flags. Latency is 2 cycles from valid_in && ready_out to valid_out when there is no stall.
REQ-020 SHALL apply the transfer and advance rules:
- A transfer occurs when valid && ready.
- Stage 2 loads when !v2 || ready_in.
- Stage 1 loads when !v1 || stage 2 loads.
- ready_out equals the stage-1 load condition.
- Throughput is 1 word/cycle.
REQ-021 SHALL hold data_out and both flags stable while valid_out && !ready_in.
REQ-022 SHALL not depend on valid_in for ready_out, to keep the handshake free of combinational loops.
REQ-023 SHALL increment corr_count or uncorr_count only on an output transfer (valid_out && ready_in) carrying the matching flag.
REQ-024 SHALL saturate both counters at 16'hFFFF.
REQ-025 SHALL give clr_counts priority over a simultaneous increment: the counter becomes 0.

Reset
REQ-026 SHALL, while rst is high, force the following: valid stages 0, valid_out 0, ready_out 0, data_out 0, flags 0, counters 0.
REQ-027 SHALL discard in-flight words on reset mid-operation, with no output transfer for them.
REQ-028 SHALL drive ready_out high in the first cycle after rst is released.

Configuration
REQ-029 SHALL, when macro HAMMING_DECODE_ERR_CNT_EN is defined, implement the counters per REQ-023..025.
REQ-030 SHALL, when HAMMING_DECODE_ERR_CNT_EN is undefined, tie corr_count and uncorr_count to 0, ignore clr_counts, and leave the datapath unchanged.

Structure
REQ-031 SHALL take ECC constants (DATA_WIDTH 16, ENC_WIDTH 21, parity position list, syndrome width 5, last valid position 21) and a syndrome-class enum (CLEAN, CORRECTED, UNCORRECTABLE) from a shared package ecc_pkg, which the encode stage also uses.
REQ-032 SHALL place syndrome computation plus correction/extraction in one combinational sub-module, hamming_correct; the pipeline and counters stay in hamming_decode.

Verification
REQ-033 SHALL cover: enc_data 21'h1FFFFE, ready_in=1 -> 2 cycles later data_out 16'hFFFF, both flags 0.
REQ-034 SHALL cover: enc_data 21'h1FFBFE (position 11 flipped) -> data_out 16'hFFFF, err_corrected 1; corr_count 1 when the macro is defined.
REQ-035 SHALL cover: enc_data 21'h008080 (positions 8 and 16, syndrome 24) -> data_out 16'h0000, err_uncorrectable 1; uncorr_count 1.
REQ-036 SHALL cover: 3 back-to-back words with ready_in=0 -> 2 words accepted, then ready_out 0; data_out stable. Raising ready_in then drains all 3 in order, one per cycle.
REQ-037 SHALL cover: clr_counts asserted in the same cycle as a corrected output transfer -> corr_count 0 next cycle.
REQ-038 SHALL cover: rst pulsed with both stages full -> valid_out 0 asynchronously and no stale word emitted after release.
